alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 32 +++
 rtl/alu_seq_regfile.sv | 34 +++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcode map and FSM state type.
// Opcode values 00000..01001 are legal; everything above LAST_LEGAL_OP is rejected.
package alu_sequencer_pkg;

    localparam int DATA_W_DEF = 19;
    localparam int OP_W       = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR = 5'b00100;
    localparam logic [OP_W-1:0] OP_MUL = 5'b00101;
    localparam logic [OP_W-1:0] OP_DIV = 5'b00110;
    localparam logic [OP_W-1:0] OP_NOT = 5'b00111;
    localparam logic [OP_W-1:0] OP_INC = 5'b01000;
    localparam logic [OP_W-1:0] OP_DEC = 5'b01001;

    localparam logic [OP_W-1:0] LAST_LEGAL_OP = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Unary operations present a zero B operand to the ALU.
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NOT) || (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: two asynchronous read ports, one synchronous
// write port, register 0 hardwired to zero.
module alu_seq_regfile #(
    parameter int DATA_W = 19,
    parameter int NREG   = 8,
    parameter int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU:
// accept (IDLE) -> drive ALU (ISSUE) -> hold response (RESP).
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and the payload holds while valid && !ready.
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OP_W-1:0]           cmd_opcode,
    input  logic [$clog2(NREG)-1:0]   cmd_rd,
    input  logic [$clog2(NREG)-1:0]   cmd_rs1,
    input  logic [$clog2(NREG)-1:0]   cmd_rs2,
    input  logic                      cmd_imm_sel,
    input  logic [DATA_W-1:0]         cmd_imm,
    output logic [OP_W-1:0]           alu_opcode,
    output logic [DATA_W-1:0]         alu_operand_a,
    output logic [DATA_W-1:0]         alu_operand_b,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero_flag,
    input  logic                      alu_div_by_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_zero,
    output logic                      rsp_dbz,
    output logic                      rsp_illegal,
    output logic                      sticky_dbz,
    input  logic                      clr_sticky,
    output state_t                    dbg_state
);

    localparam int IDX_W = $clog2(NREG);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [IDX_W-1:0]    rd_q;
    logic                imm_sel_q;
    logic [DATA_W-1:0]   a_q, rs2_q, imm_q;
    logic [DATA_W-1:0]   rs1_data, rs2_data;
    logic                accept, issue, legal;

    assign accept    = cmd_valid && cmd_ready;
    assign issue     = (state_q == ST_ISSUE);
    assign legal     = (op_q <= LAST_LEGAL_OP);
    assign dbg_state = state_q;

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (cmd_rs1),
        .rdata_a (rs1_data),
        .raddr_b (cmd_rs2),
        .rdata_b (rs2_data),
        .we      (issue && legal),
        .waddr   (rd_q),
        .wdata   (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        alu_opcode    = '0;
        alu_operand_a = '0;
        alu_operand_b = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_opcode    = op_q;
                alu_operand_a = a_q;
                alu_operand_b = is_unary(op_q) ? '0 : (imm_sel_q ? imm_q : rs2_q);
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are sampled at acceptance, so the previous writeback is already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            rd_q      <= '0;
            imm_sel_q <= 1'b0;
            a_q       <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
        end else if (accept) begin
            op_q      <= cmd_opcode;
            rd_q      <= cmd_rd;
            imm_sel_q <= cmd_imm_sel;
            a_q       <= rs1_data;
            rs2_q     <= rs2_data;
            imm_q     <= cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_dbz     <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (issue) begin
            rsp_data    <= legal ? alu_result : '0;
            rsp_zero    <= legal ? alu_zero_flag : 1'b1;
            rsp_dbz     <= legal && alu_div_by_zero;
            rsp_illegal <= !legal;
        end
    end

    // A new divide-by-zero outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_dbz <= 1'b0;
        end else if (issue && legal && alu_div_by_zero) begin
            sticky_dbz <= 1'b1;
        end else if (clr_sticky) begin
            sticky_dbz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural external ALU and a response scoreboard.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DATA_W = 19;
  localparam int NREG   = 8;
  localparam int EXP_W  = DATA_W + 3;
  localparam logic [DATA_W-1:0] ALL_ONES = 19'h7FFFF;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [4:0]        cmd_opcode;
  logic [2:0]        cmd_rd, cmd_rs1, cmd_rs2;
  logic              cmd_imm_sel;
  logic [DATA_W-1:0] cmd_imm;
  logic [4:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand_a, alu_operand_b, alu_result;
  logic              alu_zero_flag, alu_div_by_zero;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero, rsp_dbz, rsp_illegal;
  logic              sticky_dbz, clr_sticky;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];

  alu_sequencer #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_zero_flag(alu_zero_flag), .alu_div_by_zero(alu_div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_dbz(rsp_dbz), .rsp_illegal(rsp_illegal),
    .sticky_dbz(sticky_dbz), .clr_sticky(clr_sticky), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external combinational ALU
  always_comb begin
    alu_result      = '0;
    alu_div_by_zero = 1'b0;
    case (alu_opcode)
      OP_ADD: alu_result = alu_operand_a + alu_operand_b;
      OP_SUB: alu_result = alu_operand_a - alu_operand_b;
      OP_AND: alu_result = alu_operand_a & alu_operand_b;
      OP_OR:  alu_result = alu_operand_a | alu_operand_b;
      OP_XOR: alu_result = alu_operand_a ^ alu_operand_b;
      OP_MUL: alu_result = alu_operand_a * alu_operand_b;
      OP_DIV: begin
        if (alu_operand_b == '0) begin
          alu_result      = ALL_ONES;
          alu_div_by_zero = 1'b1;
        end else begin
          alu_result = alu_operand_a / alu_operand_b;
        end
      end
      OP_NOT: alu_result = ~alu_operand_a;
      OP_INC: alu_result = alu_operand_a + 19'd1;
      OP_DEC: alu_result = alu_operand_a - 19'd1;
      default: alu_result = '0;
    endcase
    alu_zero_flag = (alu_result == '0);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [EXP_W-1:0] mk(input logic ill, input logic dbz, input logic z,
                                          input logic [DATA_W-1:0] d);
    return {ill, dbz, z, d};
  endfunction

  // driver tasks
  task automatic send_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic sel, input logic [DATA_W-1:0] imm,
                          input logic [EXP_W-1:0] exp);
    int n = 0;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_rd      = rd;
    cmd_rs1     = rs1;
    cmd_rs2     = rs2;
    cmd_imm_sel = sel;
    cmd_imm     = imm;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != ST_IDLE) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_payload"}, {10'd0, rsp_illegal, rsp_dbz, rsp_zero, rsp_data}, 32'd0);
    check({tag, "_alu_opcode"}, {27'd0, alu_opcode}, 32'd0);
    check({tag, "_alu_a"}, {13'd0, alu_operand_a}, 32'd0);
    check({tag, "_alu_b"}, {13'd0, alu_operand_b}, 32'd0);
    check({tag, "_sticky"}, {31'd0, sticky_dbz}, 32'd0);
  endtask

  // scoreboard monitor
  logic             prev_v = 1'b0;
  logic             hold_v = 1'b0;
  logic [EXP_W-1:0] hold_p;
  logic [EXP_W-1:0] cur_p;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    cur_p = {rsp_illegal, rsp_dbz, rsp_zero, rsp_data};
    if (rsp_valid && !prev_v) begin
      if (acc_q.size() > 0) check("rsp_latency", cyc - acc_q.pop_front(), 2);
      else check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    if (rsp_valid && !rsp_ready) begin
      if (hold_v) check("payload_stable", {10'd0, cur_p}, {10'd0, hold_p});
      hold_p = cur_p;
      hold_v = 1'b1;
    end else begin
      hold_v = 1'b0;
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_data", {13'd0, rsp_data}, {13'd0, e[DATA_W-1:0]});
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e[DATA_W]});
        check("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, e[DATA_W+1]});
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e[DATA_W+2]});
      end else begin
        check("unexpected_rsp_hs", {31'd0, rsp_valid}, 32'd0);
      end
    end
    prev_v = rsp_valid;
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; clr_sticky = 1'b0;
    cmd_opcode = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_sel = 1'b0; cmd_imm = '0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    send_cmd(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 19'd5, mk(0, 0, 0, 19'd5));
    send_cmd(OP_SUB, 3'd2, 3'd1, 3'd1, 1'b0, 19'd0, mk(0, 0, 1, 19'd0));
    send_cmd(OP_ADD, 3'd0, 3'd2, 3'd0, 1'b1, 19'd0, mk(0, 0, 1, 19'd0));
    send_cmd(OP_DIV, 3'd3, 3'd1, 3'd0, 1'b0, 19'd0, mk(0, 1, 0, ALL_ONES));
    wait_idle();
    check("sticky_set", {31'd0, sticky_dbz}, 32'd1);

    @(negedge clk) clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    check("sticky_cleared", {31'd0, sticky_dbz}, 32'd0);

    // clear coincides with the capture edge of a new divide-by-zero
    send_cmd(OP_DIV, 3'd5, 3'd1, 3'd0, 1'b0, 19'd0, mk(0, 1, 0, ALL_ONES));
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    check("sticky_set_wins", {31'd0, sticky_dbz}, 32'd1);

    send_cmd(5'b11111, 3'd1, 3'd1, 3'd0, 1'b1, 19'd3, mk(1, 0, 1, 19'd0));
    send_cmd(OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 19'd0, mk(0, 0, 0, 19'd5));

    send_cmd(OP_DEC, 3'd6, 3'd1, 3'd0, 1'b1, 19'd7, mk(0, 0, 0, 19'd4));
    check("issue_opcode", {27'd0, alu_opcode}, {27'd0, OP_DEC});
    check("issue_operand_a", {13'd0, alu_operand_a}, 32'd5);
    check("unary_operand_b", {13'd0, alu_operand_b}, 32'd0);
    send_cmd(OP_XOR, 3'd7, 3'd1, 3'd6, 1'b0, 19'd0, mk(0, 0, 0, 19'd1));
    send_cmd(OP_NOT, 3'd0, 3'd2, 3'd0, 1'b0, 19'd0, mk(0, 0, 0, ALL_ONES));
    wait_idle();

    // response back-pressure with a competing command offered
    @(negedge clk) rsp_ready = 1'b0;
    send_cmd(OP_INC, 3'd4, 3'd3, 3'd0, 1'b0, 19'd0, mk(0, 0, 1, 19'd0));
    cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_rd = 3'd1; cmd_rs1 = 3'd0; cmd_imm_sel = 1'b1;
    cmd_imm = 19'd9;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("stall_state", {30'd0, dbg_state}, {30'd0, ST_RESP});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    send_cmd(OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 19'd0, mk(0, 0, 0, 19'd5));
    wait_idle();

    // reset in the middle of an operation
    send_cmd(OP_ADD, 3'd5, 3'd1, 3'd0, 1'b1, 19'd9, mk(0, 0, 0, 19'd14));
    check("pre_reset_state", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    send_cmd(OP_ADD, 3'd0, 3'd5, 3'd0, 1'b1, 19'd0, mk(0, 0, 1, 19'd0));
    send_cmd(OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 19'd0, mk(0, 0, 1, 19'd0));
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
